// File: rtl/regdst_pkg.sv
// Shared definitions for the destination-register select pipeline:
// handshake state encoding, well-known MIPS register numbers and the
// write-enable gating helper used when a selection is accepted.
package regdst_pkg;

    // Occupancy of the two-entry output buffer.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Architectural register numbers with special meaning.
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_e;

    // A write to $zero is architecturally a no-op, so its enable can be
    // dropped early when suppression is enabled.
    function automatic logic gate_we(
        input logic we,
        input logic is_zero,
        input logic suppress
    );
        return we & ~(suppress & is_zero);
    endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational N:1 selector over a flattened input bus. An index past the
// last input yields zero and raises out_of_range so the caller can flag it.
module mux_n_to_1 #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        q,
    output logic                    out_of_range
);

    logic [31:0] sel_ext_s;

    // Decode the index against every input; unmatched indices leave q at zero.
    always_comb begin
        sel_ext_s    = 32'(sel);
        q            = {WIDTH{1'b0}};
        out_of_range = (sel_ext_s >= 32'(NUM_IN));
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_ext_s == 32'(i)) begin
                q = d[i*WIDTH +: WIDTH];
            end else begin
                // a non-matching input does not disturb the selection
            end
        end
    end

endmodule

// File: rtl/regdst_mux_pipe.sv
// Destination-register selector between ID and EX. The selected register
// number and its gated write enable are registered into a two-entry skid
// buffer so EX back-pressure never drops or reorders a selection. FLUSH
// squashes everything held; ERR remembers any accepted out-of-range select.
module regdst_mux_pipe
    import regdst_pkg::*;
#(
    parameter int WIDTH         = 5,
    parameter int NUM_IN        = 3,
    parameter int SEL_W         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] D_IN,
    input  logic [SEL_W-1:0]        SEL,
    input  logic                    WE_IN,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    FLUSH,
    output logic [WIDTH-1:0]        OUT,
    output logic                    WE_OUT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    ERR
);

    state_e            state_r;
    logic [WIDTH-1:0]  main_val_r;
    logic              main_we_r;
    logic [WIDTH-1:0]  skid_val_r;
    logic              skid_we_r;
    logic              out_valid_r;
    logic              err_r;

    logic [WIDTH-1:0]  mux_val_s;
    logic              oor_s;
    logic [WIDTH-1:0]  pay_val_s;
    logic              pay_we_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    mux_n_to_1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .d            (D_IN),
        .sel          (SEL),
        .q            (mux_val_s),
        .out_of_range (oor_s)
    );

    // Handshake qualifiers and the payload captured on an accept.
    always_comb begin
        in_ready_s = (state_r != S_TWO) & ~RST;
        in_fire_s  = IN_VALID & in_ready_s;
        out_fire_s = out_valid_r & OUT_READY;
        if (oor_s) begin
            pay_val_s = {WIDTH{1'b0}};
        end else begin
            pay_val_s = mux_val_s;
        end
        pay_we_s = gate_we(WE_IN & ~oor_s,
                           pay_val_s == WIDTH'(REG_ZERO),
                           ZERO_SUPPRESS);
    end

    // Buffer occupancy FSM with main/skid storage and the sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= S_EMPTY;
            main_val_r  <= {WIDTH{1'b0}};
            main_we_r   <= 1'b0;
            skid_val_r  <= {WIDTH{1'b0}};
            skid_we_r   <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            // a bad select is remembered even if a flush discards the entry
            err_r <= err_r | (in_fire_s & oor_s);
            if (FLUSH) begin
                state_r     <= S_EMPTY;
                out_valid_r <= 1'b0;
                main_we_r   <= 1'b0;
                skid_we_r   <= 1'b0;
            end else begin
                case (state_r)
                    S_EMPTY: begin
                        if (in_fire_s) begin
                            state_r     <= S_ONE;
                            out_valid_r <= 1'b1;
                            main_val_r  <= pay_val_s;
                            main_we_r   <= pay_we_s;
                        end else begin
                            state_r <= S_EMPTY;
                        end
                    end
                    S_ONE: begin
                        if (in_fire_s && out_fire_s) begin
                            main_val_r <= pay_val_s;
                            main_we_r  <= pay_we_s;
                        end else if (in_fire_s) begin
                            state_r    <= S_TWO;
                            skid_val_r <= pay_val_s;
                            skid_we_r  <= pay_we_s;
                        end else if (out_fire_s) begin
                            state_r     <= S_EMPTY;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r <= S_ONE;
                        end
                    end
                    S_TWO: begin
                        // IN_READY is low here, so only a drain can happen
                        if (out_fire_s) begin
                            state_r    <= S_ONE;
                            main_val_r <= skid_val_r;
                            main_we_r  <= skid_we_r;
                        end else begin
                            state_r <= S_TWO;
                        end
                    end
                    default: begin
                        state_r     <= S_EMPTY;
                        out_valid_r <= 1'b0;
                        main_we_r   <= 1'b0;
                        skid_we_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT       = main_val_r;
    assign WE_OUT    = main_we_r;
    assign OUT_VALID = out_valid_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_regdst_mux_pipe.sv
// Bench for regdst_mux_pipe: two instances (zero suppression on and off)
// share stimulus; a queue-based reference model is compared every cycle,
// and directed scenarios pin literal expected values.
module tb_regdst_mux_pipe;

    logic        CLK;
    logic        RST;
    logic [4:0]  din [3];
    logic [14:0] D_IN;
    logic [1:0]  SEL;
    logic        WE_IN;
    logic        IN_VALID;
    logic        FLUSH;
    logic        OUT_READY;

    logic        IN_READY,  IN_READY_NZ;
    logic [4:0]  OUT,       OUT_NZ;
    logic        WE_OUT,    WE_OUT_NZ;
    logic        OUT_VALID, OUT_VALID_NZ;
    logic        ERR,       ERR_NZ;

    int checks;
    int errors;
    bit cmp_en;

    assign D_IN = {din[2], din[1], din[0]};

    regdst_mux_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .ZERO_SUPPRESS(1'b1)) dut (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .SEL(SEL), .WE_IN(WE_IN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .FLUSH(FLUSH),
        .OUT(OUT), .WE_OUT(WE_OUT), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .ERR(ERR)
    );

    regdst_mux_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .ZERO_SUPPRESS(1'b0)) dut_nz (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .SEL(SEL), .WE_IN(WE_IN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY_NZ), .FLUSH(FLUSH),
        .OUT(OUT_NZ), .WE_OUT(WE_OUT_NZ), .OUT_VALID(OUT_VALID_NZ),
        .OUT_READY(OUT_READY), .ERR(ERR_NZ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: FIFO of at most two entries -------
    typedef struct {
        logic [4:0] v;
        logic       we;
        logic       we_nz;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] m_val   = 5'd0;
    logic       m_we    = 1'b0;
    logic       m_we_nz = 1'b0;
    logic       m_err   = 1'b0;

    always @(posedge CLK) begin : model
        ent_t e;
        bit   acc;
        bit   pop;
        if (RST) begin
            mq.delete();
            m_val   = 5'd0;
            m_we    = 1'b0;
            m_we_nz = 1'b0;
            m_err   = 1'b0;
        end else begin
            acc = IN_VALID && (mq.size() < 2);
            pop = OUT_READY && (mq.size() > 0);
            if (SEL < 2'd3) begin
                e.v     = din[SEL];
                e.we    = WE_IN && (e.v != 5'd0);
                e.we_nz = WE_IN;
            end else begin
                e.v     = 5'd0;
                e.we    = 1'b0;
                e.we_nz = 1'b0;
                if (acc) m_err = 1'b1;
            end
            if (FLUSH) begin
                mq.delete();
                m_we    = 1'b0;
                m_we_nz = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(e);
                if (mq.size() > 0) begin
                    m_val   = mq[0].v;
                    m_we    = mq[0].we;
                    m_we_nz = mq[0].we_nz;
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model -------------
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("out_valid", OUT_VALID, mq.size() > 0);
            check("in_ready",  IN_READY,  (mq.size() < 2) && !RST);
            check("out",       OUT,       m_val);
            check("we_out",    WE_OUT,    m_we);
            check("err",       ERR,       m_err);
            check("nz_out_valid", OUT_VALID_NZ, mq.size() > 0);
            check("nz_out",       OUT_NZ,       m_val);
            check("nz_we_out",    WE_OUT_NZ,    m_we_nz);
            check("nz_err",       ERR_NZ,       m_err);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- directed scenarios ---------------------------------
    initial begin
        checks = 0; errors = 0; cmp_en = 1'b0;
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        WE_IN = 1'b0; SEL = 2'd0;
        din[0] = 5'd7; din[1] = 5'd12; din[2] = 5'd31;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_out", OUT, 5'd0);
        check("rst_we", WE_OUT, 1'b0);
        check("rst_valid", OUT_VALID, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_in_ready", IN_READY, 1'b0);
        RST = 1'b0;
        #1;
        check("release_in_ready", IN_READY, 1'b1);

        // basic pass: select input 1
        SEL = 2'd1; WE_IN = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        check("basic_out", OUT, 5'd12);
        check("basic_we", WE_OUT, 1'b1);
        check("basic_valid", OUT_VALID, 1'b1);
        IN_VALID = 1'b0;
        tick();
        check("drain_valid", OUT_VALID, 1'b0);
        check("hold_out", OUT, 5'd12);

        // zero suppression
        din[0] = 5'd0; SEL = 2'd0; IN_VALID = 1'b1;
        tick();
        check("zs_out", OUT, 5'd0);
        check("zs_we", WE_OUT, 1'b0);
        check("nozs_we", WE_OUT_NZ, 1'b1);
        IN_VALID = 1'b0; din[0] = 5'd7;
        tick();

        // back-pressure: 7 then 12 with downstream stalled
        OUT_READY = 1'b0; IN_VALID = 1'b1; SEL = 2'd0;
        tick();
        SEL = 2'd1;
        tick();
        check("bp_in_ready", IN_READY, 1'b0);
        check("bp_out", OUT, 5'd7);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        check("bp_out2", OUT, 5'd12);
        check("bp_in_ready2", IN_READY, 1'b1);
        tick();

        // out-of-range select
        SEL = 2'd3; WE_IN = 1'b1; IN_VALID = 1'b1;
        tick();
        check("oor_out", OUT, 5'd0);
        check("oor_we", WE_OUT, 1'b0);
        check("oor_err", ERR, 1'b1);
        SEL = 2'd2;
        tick();
        check("oor_next_out", OUT, 5'd31);
        check("oor_err_sticky", ERR, 1'b1);
        IN_VALID = 1'b0;
        tick();

        // flush from the full state
        OUT_READY = 1'b0; IN_VALID = 1'b1; SEL = 2'd0;
        tick();
        SEL = 2'd1;
        tick();
        FLUSH = 1'b1; SEL = 2'd2;
        tick();
        check("flush_valid", OUT_VALID, 1'b0);
        check("flush_in_ready", IN_READY, 1'b1);
        check("flush_we", WE_OUT, 1'b0);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        tick();
        check("flush_stays_empty", OUT_VALID, 1'b0);

        // reset while full
        OUT_READY = 1'b0; IN_VALID = 1'b1; SEL = 2'd0;
        tick();
        SEL = 2'd1;
        tick();
        check("pre_rst_out", OUT, 5'd7);
        RST = 1'b1; IN_VALID = 1'b0;
        tick();
        check("mid_rst_out", OUT, 5'd0);
        check("mid_rst_we", WE_OUT, 1'b0);
        check("mid_rst_valid", OUT_VALID, 1'b0);
        check("mid_rst_err", ERR, 1'b0);
        check("mid_rst_in_ready", IN_READY, 1'b0);
        RST = 1'b0;
        #1;
        check("post_rst_in_ready", IN_READY, 1'b1);

        // flush discards an out-of-range accept but still flags it
        FLUSH = 1'b1; IN_VALID = 1'b1; SEL = 2'd3;
        tick();
        check("flush_oor_err", ERR, 1'b1);
        check("flush_oor_valid", OUT_VALID, 1'b0);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        tick();

        // random ready/valid stream
        for (int i = 0; i < 80; i++) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = ($urandom_range(0, 3) != 0);
            SEL       = 2'($urandom_range(0, 3));
            WE_IN     = 1'($urandom_range(0, 1));
            din[0]    = 5'($urandom_range(0, 31));
            din[1]    = 5'($urandom_range(0, 31));
            din[2]    = 5'($urandom_range(0, 31));
            FLUSH     = ($urandom_range(0, 15) == 0);
            tick();
        end
        IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
        tick();
        tick();
        tick();

        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
